// File: rtl/hamming_frame_serializer.sv
// Serializes one 12-bit Hamming codeword per frame: start bit, codeword LSB first,
// optional even-parity bit, stop bit. Line idles high; txbit/txen/done are registered.
module hamming_frame_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] codein,
  input  logic        valid,
  output logic        ready,
  output logic        txbit,
  output logic        txen,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [11:0]   shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          txbit_q, txbit_d;
  logic          txen_q, txen_d;
  logic          done_q, done_d;
  logic          baud_wrap;

  assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign ready     = (state_q == IDLE);
  assign txbit     = txbit_q;
  assign txen      = txen_q;
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d  = codein;
          parity_d = ^codein;
          state_d  = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = 4'd0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_q == 4'd11) begin
            state_d = PARITY_EN ? PARITY : STOP;
            bit_d   = 4'd0;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) state_d = STOP;
      end
      STOP: begin
        if (baud_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Baud counter restarts on every state change so each line bit gets a full period.
    if (state_d != state_q || state_q == IDLE || baud_wrap) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + 1'b1;
    end

    // Outputs are decoded from next-state values so they land in registers.
    txbit_d = 1'b1;
    case (state_d)
      START:   txbit_d = 1'b0;
      DATA:    txbit_d = shift_d[0];
      PARITY:  txbit_d = parity_d;
      default: txbit_d = 1'b1;
    endcase
    txen_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 12'd0;
      parity_q <= 1'b0;
      txbit_q  <= 1'b1;
      txen_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txbit_q  <= txbit_d;
      txen_q   <= txen_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/hamming_frame_serializer.md
Name: hamming_frame_serializer

Overview:
- Transmit-side stage directly downstream of the 8-to-12 Hamming encoder.
- Accepts one 12-bit codeword per frame over a valid/ready handshake and latches it.
- Shifts the frame out one bit at a time, at a fixed number of clocks per bit, as a bit-level stream for the FSK modulator.
- Frame format: start bit, 12 codeword bits LSB first, optional even-parity bit over the codeword, stop bit; line idles high.

Parameters:
- CLKS_PER_BIT, 16, clock cycles each line bit is held; legal range >= 2.
- PARITY_EN, 1, 1 = append an even-parity bit (XOR of codein[11:0]) after codeword bit 11; 0 = omit it.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- codein  input  12  Hamming codeword from the encoder; bit 0 is sent first.
- valid  input  1  codein is valid this cycle.
- ready  output  1  serializer can accept a codeword this cycle.
- txbit  output  1  serial line level to the FSK modulator.
- txen  output  1  high while a frame is on the line; gates the modulator carrier.
- done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, txbit=1, txen=0, done=0, baud and bit counters 0, shift register 0. ready=1 from the first cycle after rst deasserts.
- Reset mid-frame: the frame is abandoned immediately and the partial frame is not resumed; next cycle txbit=1, txen=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - ready=1, txbit=1, txen=0.
  - On valid&&ready, latch codein and its parity, then go to START next cycle.
  - valid while not in IDLE is ignored; no queuing.
  - codein changes after acceptance have no effect.
- START: txbit=0, txen=1 for CLKS_PER_BIT cycles.
- DATA:
  - txbit = latched bit i, i = 0..11, each held CLKS_PER_BIT cycles; bit counter increments on baud-counter wrap.
  - After bit 11, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: txbit = XOR of latched codeword bits, held CLKS_PER_BIT cycles.
- STOP:
  - txbit=1, txen=1 for CLKS_PER_BIT cycles.
  - done=1 on the final cycle of STOP only; next cycle is IDLE.
- Timing:
  - The first START cycle is the cycle after acceptance.
  - Frame length = (14 + PARITY_EN) x CLKS_PER_BIT cycles, counted from the first START cycle to the last STOP cycle inclusive.
- Back-to-back: the earliest next acceptance is the IDLE cycle directly after done. Minimum inter-frame gap is 1 idle cycle (txbit=1, txen=0).
- Outputs txbit, txen and done are registered; no combinational path from codein or valid to any output.
- Baud counter:
  - Width clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Resets to 0 on every state change.
- Bit counter: 4 bits, counts 0..11 in DATA only.

Test Plan:
1. Reset, then idle 20 cycles with valid=0 -> ready=1, txbit=1, txen=0, done=0 throughout.
2. CLKS_PER_BIT=4, PARITY_EN=1, accept codein=0xF77 (encoder output for data 0xFF) -> txbit sequence, each bit 4 cycles:
   - start 0;
   - data 1,1,1,0,1,1,1,0,1,1,1,1;
   - parity 0;
   - stop 1.
   Frame is 60 cycles, done pulses on cycle 60, ready returns the next cycle.
3. CLKS_PER_BIT=4, PARITY_EN=1, codein=0x001 -> data bits 1 then eleven 0s, parity bit 1. With PARITY_EN=0 the same codeword gives no parity bit and a 56-cycle frame.
4. Hold valid=1 with codein=0x0A5, then 0x5A0 -> two consecutive frames separated by exactly one IDLE cycle. The second frame carries 0x5A0 and its parity 0. The 0x5A0 value presented mid-frame does not corrupt the first frame.
5. Assert rst during DATA bit 6 -> next cycle txbit=1, txen=0, done=0. Then ready=1, and a new frame with codein=0x3C3 transmits correctly from its start bit.
6. Drive valid=1 with codein=0xFFF during START, DATA, PARITY and STOP of a frame carrying 0x000 -> all transmitted data and parity bits are 0, and 0xFFF is not sent afterwards unless valid is still high in IDLE.
